// File: rtl/aes128_round_sequencer.sv
// aes128_round_sequencer: iterative AES-128 encryptor, one round per clock with on-the-fly key expansion.
// Buses are [127:0] with byte n at [127-8n -: 8], so bit 0 of the FIPS byte stream is the MSB here.
module aes128_round_sequencer #(
  parameter int NR = 10,
  parameter bit CLEAR_ON_DONE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_pt,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_ct,
  output logic         busy,
  output logic [3:0]   round
);
  if (NR != 10) begin : g_bad_nr
    $error("aes128_round_sequencer: NR must be 10");
  end
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_fsm, w_fsm_nxt;
  logic [127:0] r_state, r_key, r_ct;
  logic [7:0]   r_rcon;
  logic [3:0]   r_round;
  logic         r_ov;
  logic [127:0] w_sb, w_sr, w_mc, w_rk, w_next;
  logic [31:0]  w_t, w_k0, w_k1, w_k2, w_k3;
  logic         w_acc, w_hs, w_last;
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign w_sb[127-8*i -: 8] = sb(r_state[127-8*i -: 8]);
    assign w_sr[127-8*i -: 8] = w_sb[127-8*(4*(((i/4)+(i%4))%4)+(i%4)) -: 8];
  end
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = w_sr[127-32*c -: 8];
    assign w_a1 = w_sr[119-32*c -: 8];
    assign w_a2 = w_sr[111-32*c -: 8];
    assign w_a3 = w_sr[103-32*c -: 8];
    assign w_mc[127-32*c -: 32] = {
      xt(w_a0) ^ xt(w_a1) ^ w_a1 ^ w_a2 ^ w_a3,
      w_a0 ^ xt(w_a1) ^ xt(w_a2) ^ w_a2 ^ w_a3,
      w_a0 ^ w_a1 ^ xt(w_a2) ^ xt(w_a3) ^ w_a3,
      xt(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xt(w_a3)};
  end
  // RotWord + SubWord + rcon applied to word 3 of the current round key
  assign w_t  = {sb(r_key[23:16]) ^ r_rcon, sb(r_key[15:8]), sb(r_key[7:0]), sb(r_key[31:24])};
  assign w_k0 = r_key[127:96] ^ w_t;
  assign w_k1 = r_key[95:64] ^ w_k0;
  assign w_k2 = r_key[63:32] ^ w_k1;
  assign w_k3 = r_key[31:0] ^ w_k2;
  assign w_rk = {w_k0, w_k1, w_k2, w_k3};
  assign w_next = w_rk ^ ((r_round == 4'(NR)) ? w_sr : w_mc);
  assign w_acc  = in_valid & in_ready;
  assign w_hs   = r_ov & out_ready;
  assign w_last = (r_fsm == RUN) && (r_round == 4'(NR));
  always_ff @(posedge clk or posedge rst)
    if (rst) r_fsm <= IDLE;
    else r_fsm <= w_fsm_nxt;
  always_comb begin
    w_fsm_nxt = r_fsm;
    in_ready = (r_fsm == IDLE);
    busy = (r_fsm != IDLE);
    if (r_fsm == IDLE && in_valid) w_fsm_nxt = RUN;
    else if (w_last) w_fsm_nxt = DONE;
    else if (r_fsm == DONE && out_ready) w_fsm_nxt = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= '0;
      r_key   <= '0;
      r_ct    <= '0;
      r_rcon  <= 8'h01;
      r_round <= '0;
      r_ov    <= 1'b0;
    end else if (w_acc) begin
      r_state <= in_pt ^ in_key;
      r_key   <= in_key;
      r_rcon  <= 8'h01;
      r_round <= 4'd1;
    end else if (r_fsm == RUN) begin
      r_state <= w_next;
      r_key   <= w_rk;
      r_rcon  <= xt(r_rcon);
      if (w_last) begin
        r_ov <= 1'b1;
        r_ct <= w_next;
      end else r_round <= r_round + 4'd1;
    end else if (w_hs) begin
      r_ov    <= 1'b0;
      r_round <= '0;
      if (CLEAR_ON_DONE) begin
        r_state <= '0;
        r_key   <= '0;
        r_ct    <= '0;
      end
    end
  assign out_valid = r_ov;
  assign out_ct    = r_ct;
  assign round     = r_round;
endmodule

// File: tb/tb_aes128_round_sequencer.sv
// tb_aes128_round_sequencer: known-answer vectors, handshake timing, backpressure, back-to-back and reset checks.
module tb_aes128_round_sequencer;
  logic clk = 1'b0, rst, in_valid, out_ready;
  logic [127:0] in_pt, in_key;
  logic in_ready, out_valid, busy;
  logic [127:0] out_ct;
  logic [3:0] round;
  logic o0_in_ready, o0_out_valid, o0_busy;
  logic [127:0] o0_out_ct;
  logic [3:0] o0_round;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [7:0] sbx[256];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  aes128_round_sequencer #(.NR(10), .CLEAR_ON_DONE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pt(in_pt), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_ct(out_ct), .busy(busy), .round(round));
  aes128_round_sequencer #(.NR(10), .CLEAR_ON_DONE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o0_in_ready), .in_pt(in_pt), .in_key(in_key),
    .out_valid(o0_out_valid), .out_ready(out_ready), .out_ct(o0_out_ct), .busy(o0_busy), .round(o0_round));
  typedef struct packed {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
  } vec_t;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // S-box derived from the GF(2^8) inverse and affine map rather than a table
  task automatic build_sbox();
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      sbx[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask
  task automatic aes_model(input logic [127:0] pt, input logic [127:0] key,
                           output logic [127:0] ct, output logic [127:0] lk);
    logic [7:0] s[16], k[16], t[16], rc, a0, a1, a2, a3;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    for (int r = 1; r <= 10; r++) begin
      k[0] = k[0] ^ sbx[k[13]] ^ rc;
      k[1] = k[1] ^ sbx[k[14]];
      k[2] = k[2] ^ sbx[k[15]];
      k[3] = k[3] ^ sbx[k[12]];
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      rc = gmul(rc, 8'h02);
      for (int i = 0; i < 16; i++) t[i] = sbx[s[4*(((i/4)+(i%4))%4)+(i%4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3 ^ k[4*c];
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3 ^ k[4*c+1];
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03) ^ k[4*c+2];
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02) ^ k[4*c+3];
        end else begin
          s[4*c] = a0 ^ k[4*c]; s[4*c+1] = a1 ^ k[4*c+1];
          s[4*c+2] = a2 ^ k[4*c+2]; s[4*c+3] = a3 ^ k[4*c+3];
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      ct[127-8*i -: 8] = s[i];
      lk[127-8*i -: 8] = k[i];
    end
  endtask
  task automatic run_vec(input string nm, input logic [127:0] pt, input logic [127:0] key,
                         input logic [127:0] ct);
    int c;
    logic ok;
    logic [127:0] mct, mlk;
    aes_model(pt, key, mct, mlk);
    @(negedge clk);
    in_pt = pt; in_key = key; in_valid = 1'b1;
    chk({nm, " in_ready idle"}, 128'(in_ready), 128'd1);
    @(negedge clk);
    in_valid = 1'b0; in_pt = 'x; in_key = 'x;
    c = 0; ok = 1'b1;
    while (!out_valid && c < 30) begin
      if (round != 4'(c + 1) || !busy) ok = 1'b0;
      @(negedge clk);
      c++;
    end
    chk({nm, " latency"}, 128'(c), 128'd10);
    chk({nm, " round seq"}, 128'(ok), 128'd1);
    chk({nm, " ct"}, out_ct, ct);
    chk({nm, " done flags"}, {125'd0, in_ready, busy, out_valid}, 128'b011);
    chk({nm, " done round"}, 128'(round), 128'd10);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " after hs"}, {120'd0, round, in_ready, busy, out_valid, 1'b0}, 128'b01000);
    chk({nm, " cleared state"}, dut.r_state, 128'd0);
    chk({nm, " cleared key"}, dut.r_key, 128'd0);
    chk({nm, " held state"}, dut0.r_state, ct);
    chk({nm, " held key"}, dut0.r_key, mlk);
  endtask
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT = 128'h3925841d02dc09fbdc118597196a0b32;
  initial begin
    vec_t tbl[3];
    logic [127:0] bpt[8], bkey[8], mct, mlk;
    int c, tprev, tacc;
    logic ok;
    tbl[0] = '{pt: C1_PT, key: C1_KEY, ct: C1_CT};
    tbl[1] = '{pt: B_PT, key: B_KEY, ct: B_CT};
    tbl[2] = '{pt: 128'd0, key: 128'd0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_pt = '0; in_key = '0;
    tprev = 0;
    build_sbox();
    repeat (3) @(negedge clk);
    chk("reset outs", {out_ct, 120'd0, round, busy, out_valid}, 256'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset in_ready", 128'(in_ready), 128'd1);
    for (int v = 0; v < 3; v++) run_vec($sformatf("vec%0d", v), tbl[v].pt, tbl[v].key, tbl[v].ct);
    // backpressure: output held, next block waits a cycle past the handshake
    @(negedge clk);
    in_pt = C1_PT; in_key = C1_KEY; in_valid = 1'b1;
    @(negedge clk);
    in_pt = B_PT; in_key = B_KEY;
    c = 0;
    while (!out_valid && c < 30) begin @(negedge clk); c++; end
    chk("bp latency", 128'(c), 128'd10);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!out_valid || out_ct !== C1_CT || in_ready || round != 4'd10) ok = 1'b0;
    end
    chk("bp stable", 128'(ok), 128'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp idle gap", {125'd0, busy, in_ready, out_valid}, 128'b010);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp accept next", {124'd0, round}, 128'd1);
    c = 0;
    while (!out_valid && c < 30) begin @(negedge clk); c++; end
    chk("bp second ct", out_ct, B_CT);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    // back-to-back random blocks
    for (int j = 0; j < 8; j++) begin
      bpt[j] = {$urandom(), $urandom(), $urandom(), $urandom()};
      bkey[j] = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      aes_model(bpt[j], bkey[j], mct, mlk);
      in_pt = bpt[j]; in_key = bkey[j]; in_valid = 1'b1;
      c = 0;
      while (!(busy && round == 4'd1) && c < 40) begin @(negedge clk); c++; end
      tacc = cyc;
      if (j > 0) chk($sformatf("b2b gap %0d", j), 128'(tacc - tprev), 128'd12);
      tprev = tacc;
      c = 0;
      while (!out_valid && c < 40) begin @(negedge clk); c++; end
      chk($sformatf("b2b ct %0d", j), out_ct, mct);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    // reset in the middle of a run
    @(negedge clk);
    in_pt = C1_PT; in_key = C1_KEY; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    c = 0;
    while (round != 4'd5 && c < 30) begin @(negedge clk); c++; end
    chk("mid-run round5", 128'(round), 128'd5);
    #2 rst = 1'b1;
    #1;
    chk("async reset outs", {out_ct, 120'd0, round, busy, out_valid}, 256'd0);
    chk("async reset in_ready", 128'(in_ready), 128'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post mid reset", {124'd0, busy, in_ready, out_valid, 1'b0}, 128'b0100);
    chk("post mid state", dut.r_state, 128'd0);
    run_vec("c1 after reset", C1_PT, C1_KEY, C1_CT);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
